// File: rtl/univ_cnt.sv
// Universal modulo-MOD up/down counter with clear, clamped load, terminal-count flags and a wrap pulse.
// Define UNIV_CNT_SAT_EN to build a saturating counter instead of a wrapping one.
module univ_cnt #(
    parameter int N   = 8,
    parameter int MOD = 2 ** N
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         load,
    input  logic         en,
    input  logic         up,
    input  logic [N-1:0] d,
    output logic [N-1:0] q,
    output logic         max_tic,
    output logic         min_tic,
    output logic         wrap
);

    localparam logic [N:0] TOP = (N + 1)'(MOD - 1);

    logic [N:0]   inc;
    logic [N:0]   dec;
    logic         at_top;
    logic         at_bot;
    logic         boundary;
    logic [N-1:0] step_q;

    // Load values beyond the modulus are pinned to the last legal count.
    function automatic logic [N-1:0] clamp_load(input logic [N-1:0] v);
        logic [N:0] w;
        w = {1'b0, v};
        return (w > TOP) ? TOP[N-1:0] : v;
    endfunction

    // One extra bit exposes both the carry past MOD-1 and the borrow below 0.
    always_comb begin
        inc      = {1'b0, q} + 1'b1;
        dec      = {1'b0, q} - 1'b1;
        at_top   = (inc > TOP);
        at_bot   = dec[N];
        boundary = up ? at_top : at_bot;
        step_q   = q;
`ifdef UNIV_CNT_SAT_EN
        if (!boundary)
            step_q = up ? inc[N-1:0] : dec[N-1:0];
`else
        if (up)
            step_q = at_top ? '0 : inc[N-1:0];
        else
            step_q = at_bot ? TOP[N-1:0] : dec[N-1:0];
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q    <= '0;
            wrap <= 1'b0;
        end else if (clr) begin
            q    <= '0;
            wrap <= 1'b0;
        end else if (load) begin
            q    <= clamp_load(d);
            wrap <= 1'b0;
        end else if (en) begin
            q    <= step_q;
            wrap <= boundary;
        end else begin
            wrap <= 1'b0;
        end
    end

    assign max_tic = ({1'b0, q} == TOP);
    assign min_tic = (q == '0);

endmodule

// File: tb/tb_univ_cnt.sv
// Bench for univ_cnt: a MOD=16 and a MOD=10 instance share stimulus and are compared
// every cycle against a modular-arithmetic reference model.
module tb_univ_cnt;
    localparam int N = 4;
`ifdef UNIV_CNT_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst, clr, load, en, up;
    logic [N-1:0] d;
    logic [N-1:0] q16, q10;
    logic max16, min16, wrap16, max10, min10, wrap10;

    int errors = 0;
    int checks = 0;
    int mods[2] = '{16, 10};
    int mq[2];
    bit mw[2];

    always #5 clk = ~clk;

    univ_cnt #(.N(N), .MOD(16)) u16 (
        .clk(clk), .rst(rst), .clr(clr), .load(load), .en(en), .up(up), .d(d),
        .q(q16), .max_tic(max16), .min_tic(min16), .wrap(wrap16)
    );

    univ_cnt #(.N(N), .MOD(10)) u10 (
        .clk(clk), .rst(rst), .clr(clr), .load(load), .en(en), .up(up), .d(d),
        .q(q10), .max_tic(max10), .min_tic(min10), .wrap(wrap10)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            mq[i] = 0;
            mw[i] = 1'b0;
        end
    endtask

    task automatic model_edge();
        for (int i = 0; i < 2; i++) begin
            if (clr) begin
                mq[i] = 0;
                mw[i] = 1'b0;
            end else if (load) begin
                mq[i] = (int'(d) > mods[i] - 1) ? mods[i] - 1 : int'(d);
                mw[i] = 1'b0;
            end else if (en) begin
                bit hit;
                hit   = up ? (mq[i] == mods[i] - 1) : (mq[i] == 0);
                mw[i] = hit;
                if (!(hit && SAT))
                    mq[i] = (mq[i] + (up ? 1 : mods[i] - 1)) % mods[i];
            end else begin
                mw[i] = 1'b0;
            end
        end
    endtask

    task automatic check_all(input string ctx);
        chk({ctx, "_q16"},    32'(q16),    32'(mq[0]));
        chk({ctx, "_wrap16"}, 32'(wrap16), 32'(mw[0]));
        chk({ctx, "_max16"},  32'(max16),  32'(mq[0] == 15));
        chk({ctx, "_min16"},  32'(min16),  32'(mq[0] == 0));
        chk({ctx, "_q10"},    32'(q10),    32'(mq[1]));
        chk({ctx, "_wrap10"}, 32'(wrap10), 32'(mw[1]));
        chk({ctx, "_max10"},  32'(max10),  32'(mq[1] == 9));
        chk({ctx, "_min10"},  32'(min10),  32'(mq[1] == 0));
    endtask

    task automatic cycle(input string ctx);
        @(posedge clk);
        model_edge();
        #1;
        check_all(ctx);
    endtask

    task automatic drive(input logic c, input logic l, input logic e, input logic u, input logic [N-1:0] v);
        clr = c; load = l; en = e; up = u; d = v;
    endtask

    initial begin
        rst = 1'b1;
        drive(0, 0, 0, 1, '0);
        model_reset();
        #12;
        check_all("reset");
        @(negedge clk);
        rst = 1'b0;

        // Count up to 9, then reset asynchronously away from any rising edge.
        drive(0, 0, 1, 1, '0);
        for (int i = 0; i < 9; i++) cycle("pre_rst");
        chk("q16_at9", 32'(q16), 32'd9);
        #3 rst = 1'b1;
        model_reset();
        #1 check_all("async_rst");
        #1 rst = 1'b0;

        for (int i = 0; i < 22; i++) cycle("up");
        for (int i = 0; i < 14; i++) begin
            drive(0, 0, 1, 0, '0);
            cycle("down");
        end

        drive(0, 1, 0, 1, 4'd7);
        cycle("load7");
        drive(0, 1, 0, 1, 4'd13);
        cycle("load13");
        chk("clamp10", 32'(q10), 32'd9);

        drive(1, 1, 1, 1, 4'd5);
        cycle("clr_wins");
        drive(0, 1, 1, 1, 4'd5);
        cycle("load_wins");
        drive(0, 0, 0, 1, 4'd5);
        cycle("hold");
        cycle("hold2");

        drive(0, 1, 0, 1, 4'd3);
        cycle("load3");
        for (int i = 0; i < 4; i++) begin
            drive(0, 0, 1, (i % 2 == 0), '0);
            cycle("toggle");
        end

        drive(0, 1, 0, 1, 4'd8);
        cycle("load8");
        for (int i = 0; i < 4; i++) begin
            drive(0, 0, 1, 1, '0);
            cycle("top_edge");
        end
        drive(0, 1, 0, 0, 4'd1);
        cycle("load1");
        for (int i = 0; i < 2; i++) begin
            drive(0, 0, 1, 0, '0);
            cycle("bot_edge");
        end

        for (int i = 0; i < 400; i++) begin
            drive(($urandom_range(0, 19) == 0), ($urandom_range(0, 7) == 0),
                  ($urandom_range(0, 3) != 0), $urandom_range(0, 1) == 1,
                  N'($urandom_range(0, 15)));
            cycle("rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/univ_cnt.md
# univ_cnt

Parametrised universal counter, the general-purpose successor to the plain free-running binary counter. It counts modulo `MOD` in either direction, with enable, synchronous clear and parallel load. It provides correct active-high terminal-count flags and a registered wrap/overflow event pulse. It sits in timer, prescaler and address-sequencing paths wherever a fixed `2**N` roll-over is not enough.

## Interface
- `N`, default 8: counter width in bits, ≥ 2.
- `MOD`, default `2**N`: count modulus, `2 ≤ MOD ≤ 2**N`; valid count range is 0..MOD-1.
- `clk` input 1: single clock; all state updates on rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `clr` input 1: synchronous clear to 0.
- `load` input 1: synchronous parallel load of `d`.
- `en` input 1: count enable, one step per cycle while high.
- `up` input 1: direction; 1 = increment, 0 = decrement.
- `d` input N: load value.
- `q` output N: current count (registered).
- `max_tic` output 1: high while `q == MOD-1` (combinational from `q`).
- `min_tic` output 1: high while `q == 0` (combinational from `q`).
- `wrap` output 1: registered one-cycle pulse flagging a boundary event on the previous step.

## Operation
- Per-edge priority: `clr` > `load` > `en` > hold.
- `clr`: `q` ← 0 and `wrap` ← 0.
- `load`: `q` ← `d` if `d ≤ MOD-1`, else `q` ← MOD-1 (clamp); `wrap` ← 0.
- `en` with `up=1`:
  - `q < MOD-1`: `q` ← `q+1`.
  - `q == MOD-1`: boundary step.
- `en` with `up=0`:
  - `q > 0`: `q` ← `q-1`.
  - `q == 0`: boundary step.
- Boundary step, default build: wrap around (MOD-1 → 0 going up, 0 → MOD-1 going down), `wrap` ← 1.
- `wrap` ← 0 on every edge that is not a boundary step, including hold and non-boundary counts.
- `up` may change on any cycle; it is sampled only on the enabled edge.
- Arithmetic is done at N+1 bits internally. No overflow beyond MOD-1 is ever visible on `q`.
- `MOD == 2**N` must synthesise to plain N-bit wrap with no comparator-induced glitch in value.

## Timing
- Reset values: `q` = 0, `wrap` = 0, hence `max_tic` = 0 and `min_tic` = 1.
- `rst` asserted mid-operation forces those values immediately, independent of `clk`. The first count occurs on the first rising edge after `rst` deasserts with `en=1`.
- Latency: `q` reflects `clr`/`load`/`en` one edge after sampling.
- `max_tic`/`min_tic` follow `q` in the same cycle (zero extra latency).
- `wrap` is high for exactly the cycle after the boundary edge, i.e. aligned with the new `q` (0 or MOD-1).
- Continuous `en`: `wrap` asserts once every MOD cycles, period exact.
- Simultaneous `clr`+`load`+`en`: `clr` wins, `q` = 0, `wrap` = 0.
- `load`+`en` on the same edge: load wins, no step taken.

## Configuration
- Macro: `UNIV_CNT_SAT_EN`.
- Undefined (default): wrap-around behaviour as above.
- Defined: saturating counter.
  - At `q == MOD-1` with `up=1`, or `q == 0` with `up=0`, `q` holds and `wrap` ← 1 (saturation-hit pulse).
  - `wrap` re-asserts on every enabled edge that stays blocked.
  - `clr`/`load`/priority/reset behaviour unchanged.

## Test plan
- Reset/basic count: `N=4`, `MOD=16`; assert `rst` mid-count at `q=9` → `q`=0 at once with no clock. Release, `en=1`, `up=1` for 16 cycles → `q` 0..15 then 0; `wrap` high for exactly the one cycle with `q`=0; `max_tic` high only at `q`=15.
- Non-power-of-2 modulus: `N=4`, `MOD=10`, up → sequence 0..9,0; `wrap` period 10 cycles. Down from 0 → 9,8,…; `wrap` high with `q`=9.
- Load and clamp: `MOD=10`, `load=1`, `d=7` → `q`=7. Then `d=13` → `q`=9, `max_tic`=1, `wrap`=0.
- Priority: `clr=load=en=1`, `d=5` → `q`=0. Then `load=en=1`, `d=5` → `q`=5 with no increment. `en=0` → `q` holds 5.
- Direction change: from `q`=3, toggle `up` every cycle with `en=1` → `q` 4,3,4,3; `wrap` never asserts.
- `UNIV_CNT_SAT_EN` build: `MOD=10`, up from 8 for 4 cycles → `q` 9,9,9,9; `wrap` high on the last three. Down from 1 → `q` 0,0; `wrap` high on the second.
